// File: rtl/knight_rider_pkg.sv
// Shared definitions for the knight-rider board: pushbutton FSM encoding,
// period-select width and the common default period select.
package knight_rider_pkg;

  localparam int unsigned PERIOD_SEL_W = 2;

  // Shared with the pattern generator so both power up on the same period.
  localparam logic [PERIOD_SEL_W-1:0] DEFAULT_PERIOD_SEL = 2'd1;

  // Debounce FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    S_RELEASED    = 2'd0,
    S_PRESS_CHK   = 2'd1,
    S_PRESSED     = 2'd2,
    S_RELEASE_CHK = 2'd3
  } btn_state_e;

  // Step a period select by one, wrapping 3 -> 0.
  function automatic logic [PERIOD_SEL_W-1:0] sel_step(input logic [PERIOD_SEL_W-1:0] sel);
    return sel + PERIOD_SEL_W'(1);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous board input.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset, clears both flops to 0
//   d     - asynchronous input
//   q     - synchronized output (second flop)
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;
  logic s1_d;
  logic s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/period_sel_button.sv
// Pushbutton front end for the LED pattern generator. Synchronizes and
// debounces a raw button; each accepted press steps period_sel 0->1->2->3->0.
// Optional long-press restore to DEFAULT_SEL when PERIOD_SEL_LONG_PRESS_EN
// is defined (one restore per press).
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset
//   btn_in      - raw pushbutton, asynchronous, active-high
//   period_sel  - current period select (registered)
//   sel_changed - one-cycle pulse on the edge period_sel is updated
//   btn_level   - debounced button level (registered)
module period_sel_button
  import knight_rider_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS   = 1_000_000,
  parameter int unsigned LONG_PRESS_TICKS = 100_000_000,
  parameter logic [1:0]  DEFAULT_SEL      = DEFAULT_PERIOD_SEL,
  parameter int unsigned CNT_W            = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic [1:0] period_sel,
  output logic       sel_changed,
  output logic       btn_level
);

  // Elaboration-time parameter sanity.
  if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
    $error("period_sel_button: DEBOUNCE_TICKS must be >= 1");
  end
  if (LONG_PRESS_TICKS < 1) begin : g_bad_long_press
    $error("period_sel_button: LONG_PRESS_TICKS must be >= 1");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic s2;

  btn_sync u_btn_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s2)
  );

  btn_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PERIOD_SEL_W-1:0] sel_q, sel_d;
  logic                   sel_changed_q, sel_changed_d;
  logic                   btn_level_q, btn_level_d;

`ifdef PERIOD_SEL_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_TICKS - 1);
  logic [CNT_W-1:0] long_cnt_q, long_cnt_d;
  logic             done_q, done_d;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RELEASED;
      cnt_q         <= '0;
      sel_q         <= DEFAULT_SEL;
      sel_changed_q <= 1'b0;
      btn_level_q   <= 1'b0;
`ifdef PERIOD_SEL_LONG_PRESS_EN
      long_cnt_q    <= '0;
      done_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      sel_changed_q <= sel_changed_d;
      btn_level_q   <= btn_level_d;
`ifdef PERIOD_SEL_LONG_PRESS_EN
      long_cnt_q    <= long_cnt_d;
      done_q        <= done_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    sel_changed_d = 1'b0;
    btn_level_d   = btn_level_q;
`ifdef PERIOD_SEL_LONG_PRESS_EN
    long_cnt_d    = long_cnt_q;
    done_d        = done_q;
`endif

    case (state_q)
      S_RELEASED: begin
        if (s2) begin
          state_d = S_PRESS_CHK;
          cnt_d   = '0;
        end
      end

      S_PRESS_CHK: begin
        if (!s2) begin
          state_d = S_RELEASED;
        end else if (cnt_q == DEB_LAST) begin
          state_d       = S_PRESSED;
          sel_d         = sel_step(sel_q);
          sel_changed_d = 1'b1;
          btn_level_d   = 1'b1;
`ifdef PERIOD_SEL_LONG_PRESS_EN
          long_cnt_d    = '0;
          done_d        = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PRESSED: begin
        if (!s2) begin
          state_d = S_RELEASE_CHK;
          cnt_d   = '0;
        end
`ifdef PERIOD_SEL_LONG_PRESS_EN
        // Hold timer keeps running on the cycle we leave for release check;
        // once the restore fires the counter parks until the next press.
        if (!done_q) begin
          if (long_cnt_q == LONG_LAST) begin
            sel_d         = DEFAULT_SEL;
            sel_changed_d = 1'b1;
            done_d        = 1'b1;
          end else begin
            long_cnt_d = long_cnt_q + CNT_W'(1);
          end
        end
`endif
      end

      S_RELEASE_CHK: begin
        if (s2) begin
          state_d = S_PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = S_RELEASED;
          btn_level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign period_sel  = sel_q;
  assign sel_changed = sel_changed_q;
  assign btn_level   = btn_level_q;

endmodule

// File: doc/period_sel_button.md
Name: period_sel_button

Overview:
- Input-side companion to the LED pattern generator.
- Takes a raw, asynchronous, bouncing pushbutton and synchronizes and debounces it.
- Each accepted press steps a 2-bit period select, 0→1→2→3→0, which feeds the pattern generator's period_sel input directly.
- Sits at board top level between the button pin and the pattern generator.

Parameters:
- DEBOUNCE_TICKS, 1_000_000: consecutive stable clk cycles required to accept a press or a release; must be ≥1 (10 ms at 100 MHz).
- LONG_PRESS_TICKS, 100_000_000: cycles held in PRESSED before a long-press restore; used only with the optional feature; must be ≥1.
- DEFAULT_SEL, 2'd1: reset and long-press value of period_sel.
- CNT_W, 32: width of the debounce and long-press counters; must hold max(DEBOUNCE_TICKS, LONG_PRESS_TICKS).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-high.
- btn_in, input, 1: raw pushbutton, asynchronous to clk, active-high.
- period_sel, output, 2: current period select (registered).
- sel_changed, output, 1: one-cycle pulse on the same edge period_sel changes.
- btn_level, output, 1: debounced button level (registered).

Behaviour:
- Reset state:
  - sync flops = 0, state = S_RELEASED, cnt = 0, long_cnt = 0.
  - period_sel = DEFAULT_SEL, sel_changed = 0, btn_level = 0.
  - rst overrides all other activity on the same edge.
- Synchronizer: two flops, btn_in → s1 → s2. The FSM uses only s2.
- FSM states and transitions:
  - S_RELEASED:
    - s2=1: go to S_PRESS_CHK, cnt<=0.
  - S_PRESS_CHK:
    - s2=0: return to S_RELEASED (glitch rejected, no output change).
    - s2=1 and cnt==DEBOUNCE_TICKS-1: go to S_PRESSED; period_sel<=period_sel+1 (2-bit wrap, 3→0); sel_changed<=1; btn_level<=1; long_cnt<=0.
    - otherwise: cnt<=cnt+1.
  - S_PRESSED:
    - s2=0: go to S_RELEASE_CHK, cnt<=0.
  - S_RELEASE_CHK:
    - s2=1: return to S_PRESSED; long_cnt keeps its value.
    - s2=0 and cnt==DEBOUNCE_TICKS-1: go to S_RELEASED, btn_level<=0.
    - otherwise: cnt<=cnt+1.
- Latency:
  - Count the first edge on which btn_in is sampled high as edge 1, with btn_in held steadily high.
  - period_sel and sel_changed update on edge DEBOUNCE_TICKS+3.
  - Release, symmetrically: btn_level falls on edge DEBOUNCE_TICKS+3 after the first low sample.
- sel_changed:
  - Deasserts on the next edge.
  - Never high for two consecutive cycles.
  - Never high without period_sel changing value, except for a long-press restore where the value already equals DEFAULT_SEL (pulse still issued).
- Reset mid-press: the FSM returns to S_RELEASED. A button still held after rst deasserts is treated as a fresh press and increments after full debounce.
- Illegal state encoding: next state S_RELEASED, cnt<=0; no output change.

Optional Feature:
- Macro: PERIOD_SEL_LONG_PRESS_EN.
- Defined:
  - In S_PRESSED, long_cnt increments every cycle until it reaches LONG_PRESS_TICKS-1.
  - On that edge: period_sel<=DEFAULT_SEL, sel_changed<=1, and a per-press done flag is set.
  - The flag allows at most one restore per press.
  - The flag and long_cnt clear on entry to S_PRESSED from S_PRESS_CHK and on rst.
  - long_cnt holds during S_RELEASE_CHK.
- Undefined: no long_cnt or flag logic is synthesized; holding the button has no effect beyond the single increment.

Decomposition:
- Package knight_rider_pkg holds:
  - the FSM state localparams (S_RELEASED, S_PRESS_CHK, S_PRESSED, S_RELEASE_CHK; 2-bit encoding);
  - PERIOD_SEL_W=2;
  - DEFAULT_PERIOD_SEL=2'd1, shared with the pattern generator's default.
- One sub-module: btn_sync, a 2-flop synchronizer with reset to 0, reused for the other board inputs.

Test Plan (DEBOUNCE_TICKS=4, LONG_PRESS_TICKS=20, DEFAULT_SEL=1):
- Reset with btn_in=0 → period_sel=1, sel_changed=0, btn_level=0; these hold for 50 cycles.
- btn_in high steady from edge 1 → on edge 7: period_sel=2, sel_changed=1, btn_level=1; on edge 8: sel_changed=0. Release for 10 cycles → btn_level=0, period_sel stays 2.
- Four clean presses from reset → period_sel sequence 2,3,0,1 with exactly four sel_changed pulses.
- Bounce: btn_in high 3 cycles, low 1, high 3, low, repeated for 40 cycles → period_sel unchanged, no sel_changed. A release bounce (low 2 cycles while pressed) → btn_level stays 1 and no extra increment.
- Assert rst during S_PRESS_CHK with btn_in held → period_sel=1 after rst. Release rst with btn_in still high → period_sel=2 on the DEBOUNCE_TICKS+3 edge after rst deasserts.
- With PERIOD_SEL_LONG_PRESS_EN, from period_sel=3, hold 40 cycles → increments to 0, then restores to 1 exactly 20 cycles after entering S_PRESSED, giving 2 sel_changed pulses total. Without the macro → period_sel stays 0, 1 pulse.
